// File: rtl/lsu.sv
// Load/store unit: one outstanding access, lane alignment of store data and byte enables,
// and sign/zero extension of load data on a simple req/gnt/rvalid bus.
module lsu #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [2:0]      req_func3,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  output logic [3:0]      mem_be,
  input  logic            mem_gnt,
  input  logic            mem_rvalid,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            rsp_valid,
  output logic [XLEN-1:0] rsp_data,
  output logic            rsp_misaligned
);

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t     state;
  logic [2:0] op_func3_q;
  logic [1:0] op_off_q;

  // Unsigned variants have no store form, so they fault when used with we=1.
  function automatic logic is_fault(input logic we, input logic [2:0] f3,
                                    input logic [1:0] off);
    case (f3)
      F3_B:    return 1'b0;
      F3_H:    return off[0];
      F3_W:    return off != 2'b00;
      F3_BU:   return we;
      F3_HU:   return we | off[0];
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic [3:0] be_of(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      2'b00:   return 4'b0001 << off;
      2'b01:   return 4'b0011 << off;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [XLEN-1:0] wdata_of(input logic [2:0] f3,
                                               input logic [XLEN-1:0] wd);
    case (f3[1:0])
      2'b00:   return {4{wd[7:0]}};
      2'b01:   return {2{wd[15:0]}};
      default: return wd;
    endcase
  endfunction

  function automatic logic [XLEN-1:0] extract(input logic [2:0] f3, input logic [1:0] off,
                                              input logic [XLEN-1:0] rdata);
    logic        [XLEN-1:0] lane;
    logic signed [7:0]      lane_b;
    logic signed [15:0]     lane_h;
    logic signed [XLEN-1:0] ext;
    lane   = rdata >> {off, 3'b000};
    lane_b = lane[7:0];
    lane_h = lane[15:0];
    case (f3)
      F3_B:    ext = lane_b;
      F3_H:    ext = lane_h;
      F3_BU:   ext = XLEN'(lane[7:0]);
      F3_HU:   ext = XLEN'(lane[15:0]);
      default: ext = lane;
    endcase
    return ext;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      req_ready      <= 1'b1;
      op_func3_q     <= '0;
      op_off_q       <= '0;
      mem_req        <= 1'b0;
      mem_we         <= 1'b0;
      mem_addr       <= '0;
      mem_wdata      <= '0;
      mem_be         <= '0;
      rsp_valid      <= 1'b0;
      rsp_data       <= '0;
      rsp_misaligned <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        // Accept: capture the operation; faults skip the bus entirely.
        IDLE: begin
          if (req_valid) begin
            req_ready  <= 1'b0;
            op_func3_q <= req_func3;
            op_off_q   <= req_addr[1:0];
            if (is_fault(req_we, req_func3, req_addr[1:0])) begin
              state          <= RESP;
              rsp_valid      <= 1'b1;
              rsp_misaligned <= 1'b1;
              rsp_data       <= '0;
            end else begin
              state     <= REQ;
              mem_req   <= 1'b1;
              mem_we    <= req_we;
              mem_addr  <= {req_addr[XLEN-1:2], 2'b00};
              mem_wdata <= wdata_of(req_func3, req_wdata);
              mem_be    <= be_of(req_func3, req_addr[1:0]);
            end
          end
        end
        // Bus request held stable until granted.
        REQ: begin
          if (mem_gnt) begin
            mem_req <= 1'b0;
            if (mem_we) begin
              state          <= RESP;
              rsp_valid      <= 1'b1;
              rsp_misaligned <= 1'b0;
              rsp_data       <= '0;
            end else begin
              state <= WAIT;
            end
          end
        end
        // Load data return.
        WAIT: begin
          if (mem_rvalid) begin
            state          <= RESP;
            rsp_valid      <= 1'b1;
            rsp_misaligned <= 1'b0;
            rsp_data       <= extract(op_func3_q, op_off_q, mem_rdata);
          end
        end
        // Response pulse cycle; ready again next cycle.
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu.sv
// Bench for lsu: directed vector table, reset corner sequences and randomized
// operations checked against a byte-level reference model.
module tb_lsu;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_func3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        rsp_misaligned;

  int checks = 0;
  int errors = 0;

  lsu #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_func3(req_func3), .req_addr(req_addr), .req_wdata(req_wdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_misaligned(rsp_misaligned)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit hit, got no finish, required finish");
    $fatal(1);
  end

  typedef struct {
    logic        saw_req;
    int          req_cyc;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    int          lat;
    logic [31:0] data;
    logic        mis;
    logic        hold_ok;
    logic        ready_ok;
    logic        pulse_ok;
    logic        timeout;
  } res_t;

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          gd;
    int          rd;
    logic        e_req;
    logic [3:0]  e_be;
    logic [31:0] e_wdata;
    logic [31:0] e_data;
    logic        e_mis;
    int          e_lat;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int size_of(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return 1;
      2'b01:   return 2;
      default: return 4;
    endcase
  endfunction

  function automatic logic m_fault(input logic we, input logic [2:0] f3, input logic [31:0] a);
    if (!(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) return 1'b1;
    if (we && f3[2]) return 1'b1;
    return (int'(a[1:0]) % size_of(f3)) != 0;
  endfunction

  function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] a);
    int sz = size_of(f3);
    int off = int'(a[1:0]);
    logic [3:0] be = '0;
    for (int i = 0; i < 4; i++) be[i] = (i >= off) && (i < off + sz);
    return be;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] wd);
    int sz = size_of(f3);
    logic [31:0] o = '0;
    for (int i = 0; i < 4; i++) o[8*i +: 8] = wd[8*(i % sz) +: 8];
    return o;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a,
                                         input logic [31:0] d);
    int sz = size_of(f3);
    int off = int'(a[1:0]);
    longint v = longint'(d >> (8*off)) & ((longint'(1) << (8*sz)) - 1);
    if (!f3[2] && sz < 4 && v >= (longint'(1) << (8*sz - 1))) v -= longint'(1) << (8*sz);
    return 32'(v);
  endfunction

  // ---------------- driver / bus responder ----------------
  task automatic run_op(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] rdata,
                        input int gd, input int rd, input logic noise, output res_t r);
    int   req_cycles = 0;
    int   gnt_cyc = -1;
    logic got = 1'b0;
    r = '{default: 0};
    r.hold_ok = 1'b1; r.ready_ok = 1'b1; r.pulse_ok = 1'b1;
    req_valid = 1'b1; req_we = we; req_func3 = f3; req_addr = addr; req_wdata = wdata;
    mem_gnt = 1'b0; mem_rvalid = 1'b0;
    @(posedge clk); #1;
    for (int cyc = 1; cyc <= 40 && !got; cyc++) begin
      req_valid = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      req_we = 1'($urandom_range(0, 1)); req_func3 = 3'($urandom);
      req_addr = $urandom; req_wdata = $urandom;
      mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = $urandom;
      if (req_ready) r.ready_ok = 1'b0;
      if (mem_req) begin
        if (gnt_cyc >= 0) r.hold_ok = 1'b0;
        if (req_cycles == 0) begin
          r.saw_req = 1'b1; r.req_cyc = cyc; r.we = mem_we; r.addr = mem_addr;
          r.wdata = mem_wdata; r.be = mem_be;
        end else if (mem_we !== r.we || mem_addr !== r.addr || mem_wdata !== r.wdata ||
                     mem_be !== r.be) begin
          r.hold_ok = 1'b0;
        end
        req_cycles++;
        if (req_cycles == gd + 1) begin
          mem_gnt = 1'b1; gnt_cyc = cyc;
        end else if (noise) begin
          mem_rvalid = 1'($urandom_range(0, 1));
        end
      end else if (gnt_cyc >= 0 && cyc == gnt_cyc + rd) begin
        mem_rvalid = 1'b1; mem_rdata = rdata;
      end else if (noise) begin
        mem_gnt = 1'($urandom_range(0, 1));
      end
      if (rsp_valid) begin
        got = 1'b1; r.lat = cyc; r.data = rsp_data; r.mis = rsp_misaligned;
        req_valid = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
      end
      @(posedge clk); #1;
    end
    r.timeout = !got;
    r.pulse_ok = (rsp_valid === 1'b0) && (req_ready === 1'b1);
    mem_gnt = 1'b0; mem_rvalid = 1'b0;
  endtask

  task automatic compare(input string tag, input res_t r, input logic e_req, input logic e_we,
                         input logic [31:0] e_addr, input logic [3:0] e_be,
                         input logic [31:0] e_wdata, input logic [31:0] e_data,
                         input logic e_mis, input int e_lat);
    chk({tag, " timeout"}, 32'(r.timeout), 32'd0);
    chk({tag, " mem_req seen"}, 32'(r.saw_req), 32'(e_req));
    if (e_req) begin
      chk({tag, " mem_req cycle"}, 32'(r.req_cyc), 32'd1);
      chk({tag, " mem_we"}, 32'(r.we), 32'(e_we));
      chk({tag, " mem_addr"}, r.addr, e_addr);
      chk({tag, " mem_be"}, 32'(r.be), 32'(e_be));
      if (e_we) chk({tag, " mem_wdata"}, r.wdata, e_wdata);
      chk({tag, " bus hold"}, 32'(r.hold_ok), 32'd1);
    end
    chk({tag, " latency"}, 32'(r.lat), 32'(e_lat));
    chk({tag, " rsp_data"}, r.data, e_data);
    chk({tag, " rsp_misaligned"}, 32'(r.mis), 32'(e_mis));
    chk({tag, " ready low while busy"}, 32'(r.ready_ok), 32'd1);
    chk({tag, " single pulse"}, 32'(r.pulse_ok), 32'd1);
  endtask

  task automatic model_op(input string tag, input logic we, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] rdata, input int gd, input int rd,
                          input logic noise);
    res_t r;
    logic flt;
    int   lat;
    logic [31:0] dat;
    flt = m_fault(we, f3, addr);
    lat = flt ? 1 : (we ? gd + 2 : gd + rd + 2);
    dat = (flt || we) ? 32'd0 : m_load(f3, addr, rdata);
    run_op(we, f3, addr, wdata, rdata, gd, rd, noise, r);
    compare(tag, r, !flt, we, {addr[31:2], 2'b00}, flt ? 4'b0 : m_be(f3, addr),
            flt ? 32'd0 : m_wdata(f3, wdata), dat, flt, lat);
  endtask

  vec_t tbl[15];
  logic [2:0] ld_f3[5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

  initial begin
    res_t r;
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_func3 = '0; req_addr = '0;
    req_wdata = '0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;

    tbl[0]  = '{1'b1, 3'b000, 32'h1003, 32'h000000A5, 32'h0, 0, 1, 1'b1, 4'b1000, 32'hA5A5A5A5, 32'h0, 1'b0, 2};
    tbl[1]  = '{1'b0, 3'b000, 32'h2001, 32'h0, 32'h0000F000, 0, 1, 1'b1, 4'b0010, 32'h0, 32'hFFFFFFF0, 1'b0, 3};
    tbl[2]  = '{1'b0, 3'b100, 32'h2001, 32'h0, 32'h0000F000, 0, 1, 1'b1, 4'b0010, 32'h0, 32'h000000F0, 1'b0, 3};
    tbl[3]  = '{1'b0, 3'b101, 32'h2002, 32'h0, 32'h80011234, 0, 1, 1'b1, 4'b1100, 32'h0, 32'h00008001, 1'b0, 3};
    tbl[4]  = '{1'b0, 3'b001, 32'h2002, 32'h0, 32'h80011234, 0, 1, 1'b1, 4'b1100, 32'h0, 32'hFFFF8001, 1'b0, 3};
    tbl[5]  = '{1'b0, 3'b010, 32'h3002, 32'h0, 32'h0, 0, 1, 1'b0, 4'b0000, 32'h0, 32'h0, 1'b1, 1};
    tbl[6]  = '{1'b1, 3'b001, 32'h3001, 32'h12345678, 32'h0, 0, 1, 1'b0, 4'b0000, 32'h0, 32'h0, 1'b1, 1};
    tbl[7]  = '{1'b0, 3'b010, 32'h3000, 32'h0, 32'hDEADBEEF, 3, 2, 1'b1, 4'b1111, 32'h0, 32'hDEADBEEF, 1'b0, 7};
    tbl[8]  = '{1'b1, 3'b001, 32'h4002, 32'h1234ABCD, 32'h0, 1, 1, 1'b1, 4'b1100, 32'hABCDABCD, 32'h0, 1'b0, 3};
    tbl[9]  = '{1'b1, 3'b010, 32'h4004, 32'hCAFEF00D, 32'h0, 2, 1, 1'b1, 4'b1111, 32'hCAFEF00D, 32'h0, 1'b0, 4};
    tbl[10] = '{1'b0, 3'b011, 32'h5000, 32'h0, 32'h0, 0, 1, 1'b0, 4'b0000, 32'h0, 32'h0, 1'b1, 1};
    tbl[11] = '{1'b1, 3'b100, 32'h5000, 32'h0, 32'h0, 0, 1, 1'b0, 4'b0000, 32'h0, 32'h0, 1'b1, 1};
    tbl[12] = '{1'b0, 3'b000, 32'h6000, 32'h0, 32'h0000007F, 0, 1, 1'b1, 4'b0001, 32'h0, 32'h0000007F, 1'b0, 3};
    tbl[13] = '{1'b0, 3'b101, 32'h6003, 32'h0, 32'h0, 0, 1, 1'b0, 4'b0000, 32'h0, 32'h0, 1'b1, 1};
    tbl[14] = '{1'b0, 3'b001, 32'h6000, 32'h0, 32'h12348000, 1, 3, 1'b1, 4'b0011, 32'h0, 32'hFFFF8000, 1'b0, 6};

    #23;
    chk("reset req_ready", 32'(req_ready), 32'd1);
    chk("reset mem_req", 32'(mem_req), 32'd0);
    chk("reset mem_we", 32'(mem_we), 32'd0);
    chk("reset mem_addr", mem_addr, 32'd0);
    chk("reset mem_wdata", mem_wdata, 32'd0);
    chk("reset mem_be", 32'(mem_be), 32'd0);
    chk("reset rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset rsp_data", rsp_data, 32'd0);
    chk("reset rsp_misaligned", 32'(rsp_misaligned), 32'd0);
    #4 rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 15; i++) begin
      run_op(tbl[i].we, tbl[i].f3, tbl[i].addr, tbl[i].wdata, tbl[i].rdata,
             tbl[i].gd, tbl[i].rd, 1'b0, r);
      compare($sformatf("vec%0d", i), r, tbl[i].e_req, tbl[i].we,
              {tbl[i].addr[31:2], 2'b00}, tbl[i].e_be, tbl[i].e_wdata,
              tbl[i].e_data, tbl[i].e_mis, tbl[i].e_lat);
    end

    // Reset while waiting for load data.
    req_valid = 1'b1; req_we = 1'b0; req_func3 = 3'b010; req_addr = 32'h7000;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("wait-rst mem_req in REQ", 32'(mem_req), 32'd1);
    mem_gnt = 1'b1;
    @(posedge clk); #1;
    mem_gnt = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("wait-rst mem_req", 32'(mem_req), 32'd0);
    chk("wait-rst rsp_valid", 32'(rsp_valid), 32'd0);
    chk("wait-rst req_ready", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h11223344;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      mem_rvalid = 1'b0;
      chk($sformatf("late rvalid no rsp c%0d", c), 32'(rsp_valid), 32'd0);
      chk($sformatf("late rvalid ready c%0d", c), 32'(req_ready), 32'd1);
    end
    model_op("after wait-rst", 1'b0, 3'b001, 32'h7002, 32'h0, 32'hA5B6C7D8, 0, 1, 1'b0);

    // Reset while the bus request is pending: request must drop without a clock edge.
    req_valid = 1'b1; req_we = 1'b1; req_func3 = 3'b010; req_addr = 32'h7100;
    req_wdata = 32'h55AA55AA;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("req-rst mem_req before", 32'(mem_req), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("req-rst mem_req async", 32'(mem_req), 32'd0);
    chk("req-rst mem_be", 32'(mem_be), 32'd0);
    mem_gnt = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      mem_gnt = 1'b0;
      chk($sformatf("req-rst no rsp c%0d", c), 32'(rsp_valid), 32'd0);
      chk($sformatf("req-rst no mem_req c%0d", c), 32'(mem_req), 32'd0);
    end

    for (int i = 0; i < 200; i++) begin
      logic        we;
      logic [2:0]  f3;
      logic [31:0] addr;
      int          gd;
      int          rd;
      we = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) != 0) f3 = we ? ld_f3[$urandom_range(0, 2)] : ld_f3[$urandom_range(0, 4)];
      else f3 = 3'($urandom);
      addr = $urandom;
      if ($urandom_range(0, 1) != 0) addr[1:0] = addr[1:0] & 2'(~(size_of(f3) - 1));
      gd = $urandom_range(0, 3);
      rd = $urandom_range(1, 3);
      model_op($sformatf("rnd%0d", i), we, f3, addr, $urandom, $urandom, gd, rd, 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
